// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and state encoding for the multi-port register file
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR
    } rf_state_e;

endpackage

// File: rtl/rf_read_mux.sv
// rtl/rf_read_mux.sv - per-port read select: busy/zero gating, write bypass, storage
module rf_read_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              busy,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              w0_ok,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              w1_ok,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] data
);

    // Port 1 bypass outranks port 0; the ok flags already exclude dropped writes
    always_comb begin
        data = mem_data;
        if (busy) begin
            data = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end else if (w1_ok && (wa1 == addr)) begin
            data = wd1;
        end else if (w0_ok && (wa0 == addr)) begin
            data = wd0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, zero register and sequenced clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     wen0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     wen1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state;
    rf_state_e         state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic w0_ok;
    logic w1_ok;

    // State is a flop, so busy is registered and its reset value is 1
    assign busy = (state == CLEAR);

    // Effective write enables: dropped while clearing, on the zero register,
    // and port 0 yields to port 1 on an address collision
    assign w1_ok = !busy && wen1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign w0_ok = !busy && wen0 && !((ZERO_REG != 0) && (wa0 == '0))
                   && !(w1_ok && (wa1 == wa0));

    // Clear sequencer next state: walk ptr to the last entry then stop, no wrap
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                if (ptr == PTR_LAST) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // State register; reset (even mid-clear) restarts the clear from entry 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Storage: one entry cleared per cycle keeps the array a plain RAM
    always_ff @(posedge clock) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else begin
            if (w0_ok) begin
                mem[wa0] <= wd0;
            end
            if (w1_ok) begin
                mem[wa1] <= wd1;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            rf_read_mux #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_mux (
                .busy     (busy),
                .addr     (ra[k*ADDR_W +: ADDR_W]),
                .mem_data (mem[ra[k*ADDR_W +: ADDR_W]]),
                .w0_ok    (w0_ok),
                .wa0      (wa0),
                .wd0      (wd0),
                .w1_ok    (w1_ok),
                .wa1      (wa1),
                .wd1      (wd1),
                .data     (rd[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (ZERO_REG=1 x4 ports, ZERO_REG=0 x2 ports)
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 4;
    localparam int NRN = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NRN*AW-1:0] ra_n;
    logic [NRN*DW-1:0] rd_n;
    logic              wen0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              wen1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic              clr_req;
    logic              busy;
    logic              busy_n;

    always #5 clock = ~clock;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset), .ra(ra), .rd(rd),
        .wen0(wen0), .wa0(wa0), .wd0(wd0),
        .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRN), .ZERO_REG(0)) dut_nz (
        .clock(clock), .reset(reset), .ra(ra_n), .rd(rd_n),
        .wen0(wen0), .wa0(wa0), .wd0(wd0),
        .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .clr_req(clr_req), .busy(busy_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    typedef struct {
        string         tag;
        int            src;
        logic [DW-1:0] exp;
    } sb_t;

    sb_t sb[$];

    // Reference model state
    logic [DW-1:0] mz [32];
    logic [DW-1:0] mn [32];
    bit            bm;
    int            pm;
    bit            busy_seen;

    function automatic bit w1ok(bit z);
        return wen1 && !(z && (wa1 == 5'd0));
    endfunction

    function automatic bit w0ok(bit z);
        return wen0 && !(z && (wa0 == 5'd0)) && !(w1ok(z) && (wa1 == wa0));
    endfunction

    function automatic logic [DW-1:0] model_rd(bit z, logic [AW-1:0] a);
        if (bm) return '0;
        if (z && (a == 5'd0)) return '0;
        if (w1ok(z) && (wa1 == a)) return wd1;
        if (w0ok(z) && (wa0 == a)) return wd0;
        return z ? mz[a] : mn[a];
    endfunction

    // One clock: push expectations, compare at negedge, advance model, drive next at posedge+1
    task automatic cycle();
        sb_t e;
        logic [DW-1:0] act;
        for (int k = 0; k < NR; k++) begin
            e.tag = $sformatf("rd%0d_a%0d", k, ra[k*AW +: AW]);
            e.src = k;
            e.exp = model_rd(1'b1, ra[k*AW +: AW]);
            sb.push_back(e);
        end
        for (int k = 0; k < NRN; k++) begin
            e.tag = $sformatf("nz_rd%0d_a%0d", k, ra_n[k*AW +: AW]);
            e.src = 4 + k;
            e.exp = model_rd(1'b0, ra_n[k*AW +: AW]);
            sb.push_back(e);
        end
        e.tag = "busy";    e.src = 6; e.exp = DW'(bm); sb.push_back(e);
        e.tag = "busy_nz"; e.src = 7; e.exp = DW'(bm); sb.push_back(e);
        @(negedge clock);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.src)
                0, 1, 2, 3: act = rd[e.src*DW +: DW];
                4, 5:       act = rd_n[(e.src-4)*DW +: DW];
                6:          act = DW'(busy);
                default:    act = DW'(busy_n);
            endcase
            check(e.tag, act, e.exp);
        end
        busy_seen = busy;
        if (reset) begin
            bm = 1'b1;
            pm = 0;
        end else if (bm) begin
            mz[pm] = '0;
            mn[pm] = '0;
            if (pm == 31) begin
                bm = 1'b0;
                pm = 0;
            end else begin
                pm++;
            end
        end else begin
            if (w0ok(1'b1)) mz[wa0] = wd0;
            if (w1ok(1'b1)) mz[wa1] = wd1;
            if (w0ok(1'b0)) mn[wa0] = wd0;
            if (w1ok(1'b0)) mn[wa1] = wd1;
            if (clr_req) begin
                bm = 1'b1;
                pm = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        wen0 = 1'b0; wa0 = '0; wd0 = '0;
        wen1 = 1'b0; wa1 = '0; wd1 = '0;
        clr_req = 1'b0;
    endtask

    task automatic set_ra_all(input logic [AW-1:0] a);
        ra   = {NR{a}};
        ra_n = {NRN{a}};
    endtask

    task automatic rand_ra();
        ra   = (NR*AW)'($urandom);
        ra_n = (NRN*AW)'($urandom);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mz[i] = '0;
            mn[i] = '0;
        end
        idle_in();
        ra = '0;
        ra_n = '0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bm = 1'b1;
        pm = 0;

        // Initial clear after reset: 32 busy cycles, reads all zero
        n = 0;
        repeat (40) begin
            rand_ra();
            cycle();
            if (busy_seen) n++;
        end
        check("busy_len_reset", DW'(n), 32);

        // Same-cycle bypass then stored value
        wen0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        set_ra_all(5'd5);
        cycle();
        idle_in();
        cycle();
        check("r5_hold", rd[DW-1:0], 32'hDEADBEEF);

        // Write collision: port 1 wins
        wen0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
        wen1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222;
        set_ra_all(5'd7);
        cycle();
        idle_in();
        cycle();

        // Zero register: dropped on ZERO_REG=1, stored on ZERO_REG=0
        wen0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        set_ra_all(5'd0);
        cycle();
        idle_in();
        cycle();
        check("nz_r0_hold", rd_n[DW-1:0], 32'hFFFFFFFF);

        // Fill r1..r31 then clear, with a dropped write and an ignored clr_req mid-clear
        for (int i = 1; i < 32; i++) begin
            wen1 = 1'b1; wa1 = AW'(i); wd1 = $urandom;
            rand_ra();
            cycle();
        end
        idle_in();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        n = 0;
        repeat (40) begin
            if (n == 16) begin
                wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFEF00D;
            end
            if (n == 20) clr_req = 1'b1;
            rand_ra();
            cycle();
            idle_in();
            if (busy_seen) n++;
        end
        check("busy_len_clr", DW'(n), 32);
        for (int a = 0; a < 32; a++) begin
            set_ra_all(AW'(a));
            cycle();
        end

        // Reset in the middle of a clear restarts it
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (10) begin
            rand_ra();
            cycle();
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            rand_ra();
            cycle();
            if (busy_seen) n++;
        end
        check("busy_len_restart", DW'(n), 32);

        // Random traffic with frequent address overlap
        repeat (200) begin
            wen0 = 1'($urandom); wa0 = AW'($urandom_range(0, 7)); wd0 = $urandom;
            wen1 = 1'($urandom); wa1 = AW'($urandom_range(0, 7)); wd1 = $urandom;
            ra   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            ra_n = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            cycle();
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
